// File: rtl/dmem_responder.sv
// dmem_responder: byte-lane data-memory responder behind the control unit's memory interface
// Ports: CLK/RSTn (sync, active-low); req_valid, D_MEM_WEN (0 store, 1 load), D_MEM_BE
// (0001 byte, 0011 half, 1111 word), is_sign, D_MEM_ADDR, D_MEM_DI in; rsp_valid pulse,
// D_MEM_DOUT load result, misalign_err (qualifies rsp_valid), busy (not IDLE) out.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW = 10
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid,
    input  logic        D_MEM_WEN,
    input  logic [3:0]  D_MEM_BE,
    input  logic        is_sign,
    input  logic [31:0] D_MEM_ADDR,
    input  logic [31:0] D_MEM_DI,
    output logic        rsp_valid,
    output logic [31:0] D_MEM_DOUT,
    output logic        misalign_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RD, RSP} state_t;
    state_t state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] ram_q;
    logic [AW-1:0] idx;
    logic [1:0] lane, lane_q;
    logic [1:0] size_q;
    logic sign_q;
    logic legal, accept;
    logic [3:0] mask;
    logic [31:0] wdata, load_data;
    logic [15:0] shifted;
    logic unused_addr;
    assign idx = D_MEM_ADDR[AW+1:2];
    assign lane = D_MEM_ADDR[1:0];
    // upper address bits alias onto the RAM; fold them so they are consumed
    assign unused_addr = ^D_MEM_ADDR[31:AW+2];
    // reset wins over an accept on the same edge, so the write is gated by RSTn too
    assign accept = RSTn && state == IDLE && req_valid;
    always_comb begin
        legal = (D_MEM_BE == 4'b0001) || (D_MEM_BE == 4'b0011 && !lane[0]) || (D_MEM_BE == 4'b1111 && lane == 2'b00);
        mask = D_MEM_BE << lane;
        wdata = D_MEM_BE[1] ? (D_MEM_BE[2] ? D_MEM_DI : {2{D_MEM_DI[15:0]}}) : {4{D_MEM_DI[7:0]}};
        shifted = 16'(ram_q >> {lane_q, 3'b000});
        load_data = size_q[1] ? ram_q :
                    size_q[0] ? {{16{sign_q & shifted[15]}}, shifted} :
                                {{24{sign_q & shifted[7]}}, shifted[7:0]};
    end
    always_ff @(posedge CLK) begin
        if (accept && legal && !D_MEM_WEN)
            for (int b = 0; b < 4; b++)
                if (mask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        ram_q <= mem[idx];
    end
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
            rsp_valid <= 1'b0;
            D_MEM_DOUT <= '0;
            misalign_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    busy <= 1'b1;
                    lane_q <= lane;
                    size_q <= {D_MEM_BE[2], D_MEM_BE[1]};
                    sign_q <= is_sign;
                    if (legal && D_MEM_WEN) state <= RD;
                    else begin
                        state <= RSP;
                        rsp_valid <= 1'b1;
                        misalign_err <= !legal;
                        D_MEM_DOUT <= '0;
                    end
                end
                RD: begin
                    state <= RSP;
                    rsp_valid <= 1'b1;
                    D_MEM_DOUT <= load_data;
                end
                default: begin
                    state <= IDLE;
                    rsp_valid <= 1'b0;
                    misalign_err <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic req_valid = 1'b0;
    logic D_MEM_WEN = 1'b1;
    logic [3:0] D_MEM_BE = 4'b1111;
    logic is_sign = 1'b0;
    logic [31:0] D_MEM_ADDR = '0;
    logic [31:0] D_MEM_DI = '0;
    logic rsp_valid, misalign_err, busy;
    logic [31:0] D_MEM_DOUT;
    int tests = 0;
    int fails = 0;
    dmem_responder #(.DEPTH_WORDS(1024), .AW(10)) dut (
        .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .D_MEM_WEN(D_MEM_WEN),
        .D_MEM_BE(D_MEM_BE), .is_sign(is_sign), .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DI(D_MEM_DI),
        .rsp_valid(rsp_valid), .D_MEM_DOUT(D_MEM_DOUT), .misalign_err(misalign_err), .busy(busy)
    );
    always #5 CLK = ~CLK;
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic present(input logic wen, input logic [3:0] be, input logic sg, input logic [31:0] addr, input logic [31:0] di);
        req_valid = 1'b1;
        D_MEM_WEN = wen;
        D_MEM_BE = be;
        is_sign = sg;
        D_MEM_ADDR = addr;
        D_MEM_DI = di;
        cyc();
        req_valid = 1'b0;
    endtask
    task automatic do_store(input string tag, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] di);
        present(1'b0, be, 1'b0, addr, di);
        check({tag, "_rsp"}, rsp_valid, 1);
        check({tag, "_err"}, misalign_err, 0);
        check({tag, "_dout"}, D_MEM_DOUT, 32'h0);
        cyc();
        check({tag, "_idle"}, {rsp_valid, busy}, 0);
    endtask
    task automatic do_err(input string tag, input logic wen, input logic [3:0] be, input logic [31:0] addr);
        present(wen, be, 1'b1, addr, 32'hFFFF_FFFF);
        check({tag, "_rsp"}, rsp_valid, 1);
        check({tag, "_err"}, misalign_err, 1);
        check({tag, "_dout"}, D_MEM_DOUT, 32'h0);
        cyc();
        check({tag, "_clr"}, {rsp_valid, misalign_err, busy}, 0);
    endtask
    task automatic do_load(input string tag, input logic [3:0] be, input logic sg, input logic [31:0] addr, input logic [31:0] exp);
        present(1'b1, be, sg, addr, 32'h0);
        check({tag, "_rd"}, {rsp_valid, busy}, 32'b01);
        cyc();
        check({tag, "_rsp"}, {misalign_err, rsp_valid}, 32'b01);
        check({tag, "_dout"}, D_MEM_DOUT, exp);
        cyc();
        check({tag, "_hold"}, D_MEM_DOUT, exp);
        check({tag, "_idle"}, {rsp_valid, busy}, 0);
    endtask
    initial begin
        cyc();
        cyc();
        check("reset_outs", {rsp_valid, misalign_err, busy}, 0);
        check("reset_dout", D_MEM_DOUT, 32'h0);
        RSTn = 1'b1;
        cyc();
        do_store("st_w10", 4'b1111, 32'h10, 32'hDEADBEEF);
        do_load("ld_w10", 4'b1111, 1'b0, 32'h10, 32'hDEADBEEF);
        do_load("ld_ub11", 4'b0001, 1'b0, 32'h11, 32'h000000BE);
        do_load("ld_sb13", 4'b0001, 1'b1, 32'h13, 32'hFFFFFFDE);
        do_load("ld_uh12", 4'b0011, 1'b0, 32'h12, 32'h0000DEAD);
        do_store("st_w14", 4'b1111, 32'h14, 32'h11223344);
        do_store("st_b16", 4'b0001, 32'h16, 32'h00000080);
        do_load("ld_w14", 4'b1111, 1'b1, 32'h14, 32'h11803344);
        do_load("ld_sb16", 4'b0001, 1'b1, 32'h16, 32'hFFFFFF80);
        do_load("ld_ub16", 4'b0001, 1'b0, 32'h16, 32'h00000080);
        do_store("st_w20", 4'b1111, 32'h20, 32'h55667788);
        do_store("st_h22", 4'b0011, 32'h22, 32'h0000ABCD);
        do_load("ld_sh22", 4'b0011, 1'b1, 32'h22, 32'hFFFFABCD);
        do_load("ld_uh20", 4'b0011, 1'b1, 32'h20, 32'h00007788);
        do_err("err_h21", 1'b0, 4'b0011, 32'h21);
        do_err("err_be0101", 1'b0, 4'b0101, 32'h20);
        do_err("err_ldw22", 1'b1, 4'b1111, 32'h22);
        do_load("ld_w20", 4'b1111, 1'b0, 32'h20, 32'hABCD7788);
        do_store("st_w30", 4'b1111, 32'h30, 32'hCAFEF00D);
        present(1'b1, 4'b1111, 1'b0, 32'h30, 32'h0);
        req_valid = 1'b1;
        D_MEM_WEN = 1'b0;
        D_MEM_DI = 32'h12345678;
        check("busy_rd", {busy, rsp_valid}, 32'b10);
        cyc();
        req_valid = 1'b0;
        check("busy_rsp", rsp_valid, 1);
        check("busy_dout", D_MEM_DOUT, 32'hCAFEF00D);
        cyc();
        check("busy_idle", {rsp_valid, busy}, 0);
        do_load("ld_w30", 4'b1111, 1'b0, 32'h30, 32'hCAFEF00D);
        do_store("st_alias", 4'b1111, 32'h1004, 32'h13579BDF);
        do_load("ld_w4", 4'b1111, 1'b0, 32'h4, 32'h13579BDF);
        present(1'b1, 4'b1111, 1'b0, 32'h1004, 32'h0);
        RSTn = 1'b0;
        cyc();
        check("rst_rd_outs", {rsp_valid, misalign_err, busy}, 0);
        check("rst_rd_dout", D_MEM_DOUT, 32'h0);
        RSTn = 1'b1;
        cyc();
        check("rst_rd_norsp", {rsp_valid, busy}, 0);
        RSTn = 1'b0;
        present(1'b0, 4'b1111, 1'b0, 32'h4, 32'h0);
        check("rst_req_outs", {rsp_valid, busy}, 0);
        RSTn = 1'b1;
        cyc();
        do_load("ld_w4_kept", 4'b1111, 1'b0, 32'h4, 32'h13579BDF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
